// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: read-return owner tags and
// the default address/data widths used by the control unit and RAM wrapper.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int STREAK_W   = 4;

  // Which port a returning read belongs to; writes carry OWN_NONE.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Delay line of read-owner tags matching the RAM read latency. The tag that
// leaves the last stage marks the port whose data is on mem_rdata this cycle.
module rd_tag_pipe
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  owner_t tag_in,
  output owner_t tag_out
);

  owner_t stage [DEPTH];

  // Shift one tag per clock; reset discards every in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= OWN_NONE;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the single-port data RAM. CPU has fixed
// priority; a saturating streak counter forces a DMA grant after MAX_BURST
// consecutive CPU grants while DMA is waiting. Read data is steered back to
// the issuing port using a tag pipeline as deep as the RAM read latency.
//
// Handshake: a port raises req with wr/addr/wdata stable and holds them until
// a rising edge where req and gnt are both 1; that edge completes the
// transaction. gnt is combinational from req and the registered streak, so a
// request can be accepted in the same cycle it appears. rvalid is a one-cycle
// pulse with no back-pressure; rdata is valid with it and holds afterwards.
module data_mem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RD_LAT    = 1,   // legal 1..3
  parameter int MAX_BURST = 4    // legal 1..15
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_wr,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [STREAK_W-1:0] BURST_LIM = STREAK_W'(MAX_BURST);

  logic [STREAK_W-1:0] streak_q;
  logic                cpu_win;
  logic                dma_win;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  owner_t              issue_tag;
  owner_t              ret_tag;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic [DATA_W-1:0]   dma_rdata_q;

  // Grant selection: CPU first unless DMA has waited through a full burst.
  // Grants are forced low while Reset is asserted.
  always_comb begin
    cpu_win = 1'b0;
    dma_win = 1'b0;
    if (Reset) begin
      if (cpu_req && dma_req) begin
        if (streak_q == BURST_LIM) dma_win = 1'b1;
        else                       cpu_win = 1'b1;
      end else if (cpu_req) begin
        cpu_win = 1'b1;
      end else if (dma_req) begin
        dma_win = 1'b1;
      end
    end
  end

  assign cpu_gnt = cpu_win;
  assign dma_gnt = dma_win;

  // RAM-side mux; address and write data hold their last value when idle.
  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_wr    = 1'b0;
    issue_tag = OWN_NONE;
    if (cpu_win) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_wr    = cpu_wr;
      issue_tag = cpu_wr ? OWN_NONE : OWN_CPU;
    end else if (dma_win) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_wr    = dma_wr;
      issue_tag = dma_wr ? OWN_NONE : OWN_DMA;
    end
  end

  // Remember the last driven address/data so idle cycles keep the bus steady.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (cpu_win || dma_win) begin
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
    end
  end

  // Count CPU grants taken while DMA waits; any DMA grant or idle DMA clears it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      streak_q <= '0;
    end else if (!dma_req || dma_win) begin
      streak_q <= '0;
    end else if (cpu_win && (streak_q != BURST_LIM)) begin
      streak_q <= streak_q + STREAK_W'(1);
    end
  end

  rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_tag_pipe (
    .clk     (Clk),
    .rst_n   (Reset),
    .tag_in  (issue_tag),
    .tag_out (ret_tag)
  );

  assign cpu_rvalid = (ret_tag == OWN_CPU);
  assign dma_rvalid = (ret_tag == OWN_DMA);

  // Capture returning data per port so it holds until that port's next read.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
      if (dma_rvalid) dma_rdata_q <= mem_rdata;
    end
  end

  // Present live RAM data during the return cycle, the held copy otherwise.
  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign dma_rdata = dma_rvalid ? mem_rdata : dma_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: two instances (RD_LAT=1 and RD_LAT=3) share the
// same requester stimulus, each with its own RAM model. Grant/mux outputs are
// checked against a vector table; read returns against an expected queue.
module tb_data_mem_arbiter;

  localparam int MAXB = 4;
  localparam int EW   = 50;  // {owner[1:0], data[15:0], issue_cycle[31:0]}

  // ---------------- clock / reset ----------------
  logic Clk;
  logic Reset;
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // ---------------- shared stimulus ----------------
  logic        cpu_req, cpu_wr, dma_req, dma_wr;
  logic [7:0]  cpu_addr, dma_addr;
  logic [15:0] cpu_wdata, dma_wdata;
  logic        ram_clr;

  // ---------------- DUT with RD_LAT=1 ----------------
  logic        d1_cpu_gnt, d1_cpu_rvalid, d1_dma_gnt, d1_dma_rvalid, d1_mem_wr;
  logic [15:0] d1_cpu_rdata, d1_dma_rdata, d1_mem_wdata, d1_mem_rdata;
  logic [7:0]  d1_mem_addr;

  data_mem_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1), .MAX_BURST(MAXB)) u_dut1 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(d1_cpu_gnt), .cpu_rvalid(d1_cpu_rvalid), .cpu_rdata(d1_cpu_rdata),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(d1_dma_gnt), .dma_rvalid(d1_dma_rvalid), .dma_rdata(d1_dma_rdata),
    .mem_addr(d1_mem_addr), .mem_wr(d1_mem_wr), .mem_wdata(d1_mem_wdata),
    .mem_rdata(d1_mem_rdata)
  );

  // ---------------- DUT with RD_LAT=3 ----------------
  logic        d3_cpu_gnt, d3_cpu_rvalid, d3_dma_gnt, d3_dma_rvalid, d3_mem_wr;
  logic [15:0] d3_cpu_rdata, d3_dma_rdata, d3_mem_wdata, d3_mem_rdata;
  logic [7:0]  d3_mem_addr;

  data_mem_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(3), .MAX_BURST(MAXB)) u_dut3 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(d3_cpu_gnt), .cpu_rvalid(d3_cpu_rvalid), .cpu_rdata(d3_cpu_rdata),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(d3_dma_gnt), .dma_rvalid(d3_dma_rvalid), .dma_rdata(d3_dma_rdata),
    .mem_addr(d3_mem_addr), .mem_wr(d3_mem_wr), .mem_wdata(d3_mem_wdata),
    .mem_rdata(d3_mem_rdata)
  );

  // ---------------- RAM models (unwritten words read as {addr,addr}) --------
  logic [15:0]  ram1 [256];
  logic [255:0] wv1;
  logic [15:0]  r1;
  always @(posedge Clk) begin
    if (ram_clr) wv1 <= '0;
    else if (d1_mem_wr) begin
      ram1[d1_mem_addr] <= d1_mem_wdata;
      wv1[d1_mem_addr]  <= 1'b1;
    end
    r1 <= wv1[d1_mem_addr] ? ram1[d1_mem_addr] : {d1_mem_addr, d1_mem_addr};
  end
  assign d1_mem_rdata = r1;

  logic [15:0]  ram3 [256];
  logic [255:0] wv3;
  logic [15:0]  r3a, r3b, r3c;
  always @(posedge Clk) begin
    if (ram_clr) wv3 <= '0;
    else if (d3_mem_wr) begin
      ram3[d3_mem_addr] <= d3_mem_wdata;
      wv3[d3_mem_addr]  <= 1'b1;
    end
    r3a <= wv3[d3_mem_addr] ? ram3[d3_mem_addr] : {d3_mem_addr, d3_mem_addr};
    r3b <= r3a;
    r3c <= r3b;
  end
  assign d3_mem_rdata = r3c;

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] exp_q3[$];
  logic [15:0]   sh_mem [256];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_ret(input string nm, input int lat, input logic cv, input logic [15:0] cd,
                           input logic dv, input logic [15:0] dd, input logic [EW-1:0] e);
    logic [1:0] own;
    own = e[49:48];
    chk({nm, " rvalid {cpu,dma}"}, {30'd0, cv, dv}, {30'd0, own == 2'd1, own == 2'd2});
    chk({nm, " rdata"}, {16'd0, (own == 2'd1) ? cd : dd}, {16'd0, e[47:32]});
    chk({nm, " read latency"}, cyc - int'(e[31:0]), lat);
  endtask

  // Pops and compares read returns for both DUTs; called at every negedge.
  task automatic monitor();
    logic [EW-1:0] e;
    if (d1_cpu_rvalid || d1_dma_rvalid) begin
      if (exp_q1.size() == 0) chk("d1 unexpected rvalid", {d1_cpu_rvalid, d1_dma_rvalid}, 0);
      else begin
        e = exp_q1.pop_front();
        check_ret("d1", 1, d1_cpu_rvalid, d1_cpu_rdata, d1_dma_rvalid, d1_dma_rdata, e);
      end
    end
    if (d3_cpu_rvalid || d3_dma_rvalid) begin
      if (exp_q3.size() == 0) chk("d3 unexpected rvalid", {d3_cpu_rvalid, d3_dma_rvalid}, 0);
      else begin
        e = exp_q3.pop_front();
        check_ret("d3", 3, d3_cpu_rvalid, d3_cpu_rdata, d3_dma_rvalid, d3_dma_rdata, e);
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        cr, cw; logic [7:0] ca; logic [15:0] cd;
    logic        dr, dw; logic [7:0] da; logic [15:0] dd;
    logic        eg_cpu, eg_dma, e_wr; logic [7:0] e_addr; logic [15:0] e_wdata;
  } vec_t;

  function automatic vec_t mk(input logic cr, cw, input logic [7:0] ca, input logic [15:0] cd,
                              input logic dr, dw, input logic [7:0] da, input logic [15:0] dd,
                              input logic egc, egd, ewr, input logic [7:0] ea, input logic [15:0] ewd);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.eg_cpu = egc; v.eg_dma = egd; v.e_wr = ewr; v.e_addr = ea; v.e_wdata = ewd;
    return v;
  endfunction

  // Drive one cycle (called just after a rising edge), check at the negedge,
  // record expected read returns, then advance to just after the next edge.
  task automatic apply(input vec_t v, input bit push_en);
    cpu_req = v.cr; cpu_wr = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd;
    dma_req = v.dr; dma_wr = v.dw; dma_addr = v.da; dma_wdata = v.dd;
    @(negedge Clk);
    chk("d1 cpu_gnt", d1_cpu_gnt, v.eg_cpu);
    chk("d1 dma_gnt", d1_dma_gnt, v.eg_dma);
    chk("d1 mem_wr", d1_mem_wr, v.e_wr);
    chk("d1 mem_addr", d1_mem_addr, v.e_addr);
    chk("d1 mem_wdata", d1_mem_wdata, v.e_wdata);
    chk("d3 cpu_gnt", d3_cpu_gnt, v.eg_cpu);
    chk("d3 dma_gnt", d3_dma_gnt, v.eg_dma);
    chk("d3 mem_wr", d3_mem_wr, v.e_wr);
    chk("d3 mem_addr", d3_mem_addr, v.e_addr);
    chk("d3 mem_wdata", d3_mem_wdata, v.e_wdata);
    monitor();
    if (push_en) begin
      if (v.eg_cpu && !v.cw) begin
        exp_q1.push_back({2'd1, sh_mem[v.ca], 32'(cyc)});
        exp_q3.push_back({2'd1, sh_mem[v.ca], 32'(cyc)});
      end
      if (v.eg_dma && !v.dw) begin
        exp_q1.push_back({2'd2, sh_mem[v.da], 32'(cyc)});
        exp_q3.push_back({2'd2, sh_mem[v.da], 32'(cyc)});
      end
      if (v.eg_cpu && v.cw) sh_mem[v.ca] = v.cd;
      if (v.eg_dma && v.dw) sh_mem[v.da] = v.dd;
    end
    @(posedge Clk); #1;
  endtask

  task automatic idle_cycle();
    cpu_req = 1'b0; dma_req = 1'b0;
    @(negedge Clk);
    monitor();
    @(posedge Clk); #1;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, " d1 rvalid"}, {d1_cpu_rvalid, d1_dma_rvalid}, 0);
    chk({nm, " d3 rvalid"}, {d3_cpu_rvalid, d3_dma_rvalid}, 0);
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl[$];

  initial begin
    logic [7:0] ca, da;
    bit dg;
    for (int i = 0; i < 256; i++) sh_mem[i] = {i[7:0], i[7:0]};
    Reset = 1'b0; ram_clr = 1'b1;
    cpu_req = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_wr = 0; dma_addr = 0; dma_wdata = 0;
    repeat (2) @(posedge Clk);
    #1;
    // Reset state with no requests.
    chk("rst d1 gnt", {d1_cpu_gnt, d1_dma_gnt}, 0);
    chk("rst d3 gnt", {d3_cpu_gnt, d3_dma_gnt}, 0);
    chk_quiet("rst");
    chk("rst d1 mem_wr", d1_mem_wr, 0);
    chk("rst d1 mem_addr", d1_mem_addr, 0);
    chk("rst d1 mem_wdata", d1_mem_wdata, 0);
    chk("rst d1 rdata", {d1_cpu_rdata, d1_dma_rdata}, 0);
    chk("rst d3 rdata", {d3_cpu_rdata, d3_dma_rdata}, 0);
    // Requests during reset must not be granted.
    cpu_req = 1; cpu_wr = 1; cpu_addr = 8'hFF; cpu_wdata = 16'hFFFF; dma_req = 1;
    #1;
    chk("rst req d1 gnt", {d1_cpu_gnt, d1_dma_gnt}, 0);
    chk("rst req d1 mem_wr", d1_mem_wr, 0);
    chk("rst req d1 mem_addr", d1_mem_addr, 0);
    chk("rst req d3 mem_wdata", d3_mem_wdata, 0);
    cpu_req = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0; dma_req = 0;
    @(negedge Clk);
    Reset = 1'b1; ram_clr = 1'b0;
    @(posedge Clk); #1;

    // Table: idle, CPU write/read, DMA write + CPU read, interleave, burst.
    tbl.push_back(mk(0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,0,0,8'h00,16'h0000));
    tbl.push_back(mk(1,1,8'hBC,16'h1234, 0,0,8'h00,16'h0000, 1,0,1,8'hBC,16'h1234));
    tbl.push_back(mk(1,0,8'hBC,16'h0000, 0,0,8'h00,16'h0000, 1,0,0,8'hBC,16'h0000));
    tbl.push_back(mk(0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,0,0,8'hBC,16'h0000));
    tbl.push_back(mk(0,0,8'h00,16'h0000, 1,1,8'h10,16'hA5A5, 0,1,1,8'h10,16'hA5A5));
    tbl.push_back(mk(1,0,8'h10,16'h0000, 0,0,8'h00,16'h0000, 1,0,0,8'h10,16'h0000));
    tbl.push_back(mk(1,0,8'h01,16'h0000, 0,0,8'h00,16'h0000, 1,0,0,8'h01,16'h0000));
    tbl.push_back(mk(0,0,8'h00,16'h0000, 1,0,8'h02,16'h0000, 0,1,0,8'h02,16'h0000));
    tbl.push_back(mk(1,0,8'h03,16'h0000, 0,0,8'h00,16'h0000, 1,0,0,8'h03,16'h0000));
    ca = 8'h30; da = 8'h40;
    for (int k = 0; k < 2 * (MAXB + 1); k++) begin
      dg = ((k % (MAXB + 1)) == MAXB);
      tbl.push_back(mk(1,0,ca,16'h0000, 1,0,da,16'h0000, !dg,dg,0, dg ? da : ca, 16'h0000));
      if (dg) da = da + 8'd1; else ca = ca + 8'd1;
    end
    tbl.push_back(mk(0,0,8'h00,16'h0000, 1,0,8'h10,16'h0000, 0,1,0,8'h10,16'h0000));
    tbl.push_back(mk(0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,0,0,8'h10,16'h0000));
    tbl.push_back(mk(1,1,8'h50,16'hBEEF, 1,0,8'h50,16'h0000, 1,0,1,8'h50,16'hBEEF));
    tbl.push_back(mk(1,0,8'h50,16'h0000, 1,0,8'h50,16'h0000, 1,0,0,8'h50,16'h0000));
    tbl.push_back(mk(0,0,8'h00,16'h0000, 1,0,8'h50,16'h0000, 0,1,0,8'h50,16'h0000));
    tbl.push_back(mk(0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,0,0,8'h50,16'h0000));
    foreach (tbl[i]) apply(tbl[i], 1'b1);

    repeat (4) idle_cycle();
    chk("queue d1 drained before reset test", exp_q1.size(), 0);
    chk("queue d3 drained before reset test", exp_q3.size(), 0);

    // Reset mid-operation: contended read leaves streak at 1 and a read in flight.
    apply(mk(1,0,8'h60,16'h0000, 1,0,8'h61,16'h0000, 1,0,0,8'h60,16'h0000), 1'b0);
    Reset = 1'b0;
    cpu_req = 0; dma_req = 0;
    @(negedge Clk);
    chk_quiet("in reset");
    @(posedge Clk);
    @(negedge Clk);
    chk_quiet("in reset 2");
    Reset = 1'b1;
    @(posedge Clk); #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      chk_quiet("after reset release");
      @(posedge Clk); #1;
    end
    // Streak restarts at 0: full CPU burst before the DMA grant.
    ca = 8'h70; da = 8'h78;
    for (int k = 0; k <= MAXB; k++) begin
      dg = (k == MAXB);
      apply(mk(1,0,ca,16'h0000, 1,0,da,16'h0000, !dg,dg,0, dg ? da : ca, 16'h0000), 1'b1);
      if (!dg) ca = ca + 8'd1;
    end
    repeat (6) idle_cycle();
    chk("queue d1 drained at end", exp_q1.size(), 0);
    chk("queue d3 drained at end", exp_q3.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
